inert_spi_resp: RTL and testbench
=================================

INERT_SPI_RESP -- requirements
Module: inert_spi_resp

Interface
REQ-001 Parameter WHO_AM_I, default 8'h6A, value returned on a read of address 0x0F.
REQ-002 Parameter SYNC_STG, default 2, number of flops in each SS_n/SCLK/MOSI synchronizer (legal range 2..3).
REQ-003 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port SS_n  input  1  SPI slave select, active-low, asynchronous to clk.
REQ-006 Port SCLK  input  1  SPI clock, idles high, asynchronous to clk.
REQ-007 Port MOSI  input  1  SPI data from master.
REQ-008 Port MISO  output  1  SPI data to master.
REQ-009 Port INT  output  1  data-ready interrupt, active-high.
REQ-010 Port smpl_stb  input  1  one-clk pulse: new rate sample present on the rate inputs.
REQ-011 Port ptch_rt, roll_rt, yaw_rt  input  16 each  signed rate samples.
REQ-012 Port int_en  output  1  mirror of INT1_CTRL[1].

Function
REQ-013 SS_n, SCLK, MOSI SHALL each pass through SYNC_STG flops before use; SCLK edges SHALL be detected on the synchronized signal.
REQ-014 Frame SHALL be 16 bits, MSB first; MOSI sampled on synchronized SCLK rise; bit15=1 read / 0 write, bits14:8 address, bits7:0 write data.
REQ-015 FSM states: IDLE (SS_n high), XFER (SS_n low, rise count 0..15), HOLD (16 rises seen, waiting for SS_n rise).
REQ-016 IDLE->XFER on synchronized SS_n fall; XFER->HOLD on 16th rise; XFER or HOLD ->IDLE on SS_n rise.
REQ-017 SCLK rises in HOLD SHALL be ignored (no shifting, no count wrap).
REQ-018 Write commit SHALL occur only on HOLD->IDLE with bit15=0; an SS_n rise from XFER (short frame) SHALL abort with no register or INT change.
REQ-019 Register map: 0x0D INT1_CTRL RW; 0x10 CTRL1_XL RW; 0x11 CTRL2_G RW; 0x0F WHO_AM_I RO; 0x22/0x23 ptch L/H; 0x24/0x25 roll L/H; 0x26/0x27 yaw L/H (RO).
REQ-020 Writes to RO or unmapped addresses SHALL be ignored; reads of unmapped addresses SHALL return 8'h00.
REQ-021 MISO SHALL be 0 for frame bits 15:8 and whenever SS_n is high.
REQ-022 On the 8th rise, read byte for the received address SHALL load the 8-bit TX shifter; MISO = TX[7]; TX shifts left on each SCLK fall after rise 8, so data bit7 is valid before rise 9.
REQ-023 On smpl_stb in IDLE, ptch/roll/yaw rates SHALL be captured into data registers the next clk.
REQ-024 smpl_stb in XFER/HOLD SHALL set a pending flag; capture SHALL occur on entry to IDLE; a second strobe while pending SHALL overwrite the pending sample (latest wins).
REQ-025 INT SHALL set on capture when INT1_CTRL[1]=1 and clear on HOLD->IDLE of a read of 0x27.
REQ-026 Simultaneous INT set and clear SHALL leave INT=1.
REQ-027 Writing INT1_CTRL[1]=0 SHALL clear INT at commit.
REQ-028 Correct operation SHALL be guaranteed for SCLK high and low phases each >= 4 clk and SS_n high >= 4 clk between frames.

Reset
REQ-029 rst SHALL immediately force: FSM IDLE, counters 0, TX 0, MISO 0, INT 0, int_en 0, pending 0, all RW and data registers 8'h00, synchronizers to idle (SS_n=1, SCLK=1, MOSI=0).
REQ-030 rst mid-frame SHALL discard the frame; the first frame after rst release SHALL begin at the next SS_n fall.

Verification
REQ-031 Read 0x8F00 -> MISO returns 16'h006A; no INT change.
REQ-032 Write 0x0D02, then smpl_stb with ptch_rt=16'h1234 -> INT=1 within 2 clk; read 0xA200 returns 16'h0034, read 0xA300 returns 16'h0012.
REQ-033 INT=1, read 0xA7xx -> INT falls at SS_n rise; read 0xA6xx instead -> INT stays 1.
REQ-034 Write 0x1160 aborted after 10 bits -> read 0x9100 returns 16'h0000; next full frame decodes correctly.
REQ-035 smpl_stb (yaw_rt=16'hBEEF) during a read of 0x26 -> that read returns old value; after SS_n rise, read 0xA6/0xA7 returns 8'hEF/8'hBE and INT sets if enabled.
REQ-036 rst pulsed mid-write of 0x0D02 -> int_en=0, MISO=0, INT=0; subsequent read of 0x0F returns 8'h6A.

Source files
------------

// File: rtl/inert_spi_resp.sv
// SPI register-slave front end for an inertial sensor.
// Decodes 16-bit SPI frames (MSB first, bit15 = read, bits14:8 = address,
// bits7:0 = write data), serves a small register map and latches rate samples.
// Ports: clk/rst (async active-high), SS_n/SCLK/MOSI (asynchronous SPI in),
// MISO (SPI out), INT (data-ready), smpl_stb + ptch_rt/roll_rt/yaw_rt (rate
// samples), int_en (INT1_CTRL[1]).
module inert_spi_resp #(
  parameter logic [7:0]  WHO_AM_I = 8'h6A,
  parameter int unsigned SYNC_STG = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        INT,
  input  logic        smpl_stb,
  input  logic [15:0] ptch_rt,
  input  logic [15:0] roll_rt,
  input  logic [15:0] yaw_rt,
  output logic        int_en
);

  localparam logic [6:0] A_INT1_CTRL = 7'h0D;
  localparam logic [6:0] A_WHO_AM_I  = 7'h0F;
  localparam logic [6:0] A_CTRL1_XL  = 7'h10;
  localparam logic [6:0] A_CTRL2_G   = 7'h11;
  localparam logic [6:0] A_PTCH_L    = 7'h22;
  localparam logic [6:0] A_PTCH_H    = 7'h23;
  localparam logic [6:0] A_ROLL_L    = 7'h24;
  localparam logic [6:0] A_ROLL_H    = 7'h25;
  localparam logic [6:0] A_YAW_L     = 7'h26;
  localparam logic [6:0] A_YAW_H     = 7'h27;
  localparam logic [3:0] RD_LOAD     = 4'd7;   // count before the 8th rise
  localparam logic [3:0] SHIFT_FROM  = 4'd9;   // first fall that shifts TX
  localparam logic [3:0] LAST_BIT    = 4'd15;

  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_HOLD} state_t;

  state_t state_q, state_d;
  logic [SYNC_STG-1:0] ss_sync_q, ss_sync_d, sclk_sync_q, sclk_sync_d, mosi_sync_q, mosi_sync_d;
  logic        sclk_prev_q, sclk_prev_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] rx_q, rx_d;
  logic [7:0]  tx_q, tx_d;
  logic        miso_q, miso_d, int_q, int_d, pend_q, pend_d;
  logic [7:0]  int1_ctrl_q, int1_ctrl_d, ctrl1_q, ctrl1_d, ctrl2_q, ctrl2_d;
  logic [15:0] ptch_q, ptch_d, roll_q, roll_d, yaw_q, yaw_d;
  logic [15:0] pptch_q, pptch_d, proll_q, proll_d, pyaw_q, pyaw_d;

  logic       ss_s, sclk_s, mosi_s, sclk_rise, sclk_fall;
  logic       to_idle, commit, cap, int_clr;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;

  assign ss_s      = ss_sync_q[SYNC_STG-1];
  assign sclk_s    = sclk_sync_q[SYNC_STG-1];
  assign mosi_s    = mosi_sync_q[SYNC_STG-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  assign MISO   = miso_q;
  assign INT    = int_q;
  assign int_en = int1_ctrl_q[1];

  // Synchronizer shift chains and SCLK edge history.
  always_comb begin
    ss_sync_d   = {ss_sync_q[SYNC_STG-2:0], SS_n};
    sclk_sync_d = {sclk_sync_q[SYNC_STG-2:0], SCLK};
    mosi_sync_d = {mosi_sync_q[SYNC_STG-2:0], MOSI};
    sclk_prev_d = sclk_s;
  end

  // Read mux; the address is complete once the 8th bit is on mosi_s.
  always_comb begin
    rd_addr = {rx_q[5:0], mosi_s};
    rd_data = 8'h00;
    case (rd_addr)
      A_INT1_CTRL: rd_data = int1_ctrl_q;
      A_WHO_AM_I:  rd_data = WHO_AM_I;
      A_CTRL1_XL:  rd_data = ctrl1_q;
      A_CTRL2_G:   rd_data = ctrl2_q;
      A_PTCH_L:    rd_data = ptch_q[7:0];
      A_PTCH_H:    rd_data = ptch_q[15:8];
      A_ROLL_L:    rd_data = roll_q[7:0];
      A_ROLL_H:    rd_data = roll_q[15:8];
      A_YAW_L:     rd_data = yaw_q[7:0];
      A_YAW_H:     rd_data = yaw_q[15:8];
      default:     rd_data = 8'h00;
    endcase
  end

  // Frame FSM, register commit, sample capture and INT.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    int1_ctrl_d = int1_ctrl_q;
    ctrl1_d     = ctrl1_q;
    ctrl2_d     = ctrl2_q;
    ptch_d      = ptch_q;
    roll_d      = roll_q;
    yaw_d       = yaw_q;
    pend_d      = pend_q;
    pptch_d     = pptch_q;
    proll_d     = proll_q;
    pyaw_d      = pyaw_q;
    to_idle     = 1'b0;
    commit      = 1'b0;
    cap         = 1'b0;
    int_clr     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d  = 8'h00;
        cnt_d = 4'd0;
        if (!ss_s) state_d = ST_XFER;
      end
      ST_XFER: begin
        if (ss_s) begin
          state_d = ST_IDLE;
          to_idle = 1'b1;
        end else if (sclk_rise) begin
          rx_d = {rx_q[14:0], mosi_s};
          if (cnt_q == RD_LOAD) tx_d = rd_data;
          if (cnt_q == LAST_BIT) state_d = ST_HOLD;
          else                   cnt_d = cnt_q + 4'd1;
        end else if (sclk_fall && cnt_q >= SHIFT_FROM) begin
          tx_d = {tx_q[6:0], 1'b0};
        end
      end
      ST_HOLD: begin
        if (ss_s) begin
          state_d = ST_IDLE;
          to_idle = 1'b1;
          commit  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (to_idle) begin
      tx_d  = 8'h00;
      cnt_d = 4'd0;
    end

    if (commit) begin
      if (!rx_q[15]) begin
        case (rx_q[14:8])
          A_INT1_CTRL: begin
            int1_ctrl_d = rx_q[7:0];
            int_clr     = ~rx_q[1];
          end
          A_CTRL1_XL: ctrl1_d = rx_q[7:0];
          A_CTRL2_G:  ctrl2_d = rx_q[7:0];
          default: ;
        endcase
      end else if (rx_q[14:8] == A_YAW_H) begin
        int_clr = 1'b1;
      end
    end

    // Mid-frame strobes are parked; latest one wins.
    if (smpl_stb && state_q != ST_IDLE && !to_idle) begin
      pend_d  = 1'b1;
      pptch_d = ptch_rt;
      proll_d = roll_rt;
      pyaw_d  = yaw_rt;
    end

    if (smpl_stb && (state_q == ST_IDLE || to_idle)) begin
      cap    = 1'b1;
      ptch_d = ptch_rt;
      roll_d = roll_rt;
      yaw_d  = yaw_rt;
      pend_d = 1'b0;
    end else if (to_idle && pend_q) begin
      cap    = 1'b1;
      ptch_d = pptch_q;
      roll_d = proll_q;
      yaw_d  = pyaw_q;
      pend_d = 1'b0;
    end

    // Set beats clear when both land on the same cycle.
    int_d = int_q;
    if (int_clr) int_d = 1'b0;
    if (cap && int1_ctrl_q[1]) int_d = 1'b1;

    miso_d = (state_d != ST_IDLE) ? tx_d[7] : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_sync_q   <= '1;
      sclk_sync_q <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      rx_q        <= 16'h0000;
      tx_q        <= 8'h00;
      miso_q      <= 1'b0;
      int_q       <= 1'b0;
      pend_q      <= 1'b0;
      int1_ctrl_q <= 8'h00;
      ctrl1_q     <= 8'h00;
      ctrl2_q     <= 8'h00;
      ptch_q      <= 16'h0000;
      roll_q      <= 16'h0000;
      yaw_q       <= 16'h0000;
      pptch_q     <= 16'h0000;
      proll_q     <= 16'h0000;
      pyaw_q      <= 16'h0000;
    end else begin
      ss_sync_q   <= ss_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      int_q       <= int_d;
      pend_q      <= pend_d;
      int1_ctrl_q <= int1_ctrl_d;
      ctrl1_q     <= ctrl1_d;
      ctrl2_q     <= ctrl2_d;
      ptch_q      <= ptch_d;
      roll_q      <= roll_d;
      yaw_q       <= yaw_d;
      pptch_q     <= pptch_d;
      proll_q     <= proll_d;
      pyaw_q      <= pyaw_d;
    end
  end

endmodule

// File: tb/tb_inert_spi_resp.sv
// Self-checking bench for inert_spi_resp: an SPI master drives full, short and
// over-long frames; a register-map model predicts read data, int_en and INT.
module tb_inert_spi_resp;
  localparam int HALF = 8;   // SCLK half period in clk cycles

  logic        clk = 1'b0;
  logic        rst, SS_n, SCLK, MOSI, smpl_stb;
  logic        MISO, INT, int_en;
  logic [15:0] ptch_rt, roll_rt, yaw_rt;

  int total = 0;
  int passed = 0;

  // Model: flat 128-entry byte map; unmapped entries stay zero forever.
  logic [7:0] m_regs [0:127];
  logic       m_int;

  always #5 clk = ~clk;

  inert_spi_resp #(.WHO_AM_I(8'h6A), .SYNC_STG(2)) dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .INT(INT), .smpl_stb(smpl_stb), .ptch_rt(ptch_rt), .roll_rt(roll_rt),
    .yaw_rt(yaw_rt), .int_en(int_en)
  );

  function automatic bit is_rw(input logic [6:0] a);
    return (a == 7'h0D) || (a == 7'h10) || (a == 7'h11);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 128; i++) m_regs[i] = 8'h00;
    m_regs[7'h0F] = 8'h6A;
    m_int = 1'b0;
  endtask

  task automatic model_capture(input logic [15:0] p, input logic [15:0] r,
                               input logic [15:0] y, input logic en);
    m_regs[7'h22] = p[7:0];  m_regs[7'h23] = p[15:8];
    m_regs[7'h24] = r[7:0];  m_regs[7'h25] = r[15:8];
    m_regs[7'h26] = y[7:0];  m_regs[7'h27] = y[15:8];
    if (en) m_int = 1'b1;
  endtask

  // Frame end: commit only for complete frames, then any parked sample.
  task automatic model_frame(input logic [15:0] w, input int nbits, input bit had_stb);
    logic       old_en;
    logic [6:0] a;
    old_en = m_regs[7'h0D][1];
    a = w[14:8];
    if (nbits >= 16) begin
      if (!w[15]) begin
        if (is_rw(a)) begin
          m_regs[a] = w[7:0];
          if (a == 7'h0D && !w[1]) m_int = 1'b0;
        end
      end else if (a == 7'h27) begin
        m_int = 1'b0;
      end
    end
    if (had_stb) model_capture(ptch_rt, roll_rt, yaw_rt, old_en);
  endtask

  // SPI mode-3 master: drive on fall, sample MISO just before rise.
  task automatic spi_frame(input logic [15:0] w, input int nbits, input int stb_bit,
                           output logic [15:0] r);
    logic b;
    r = 16'h0000;
    @(negedge clk); SS_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      b = (i < 16) ? w[15 - (i % 16)] : 1'($urandom_range(0, 1));
      SCLK = 1'b0;
      MOSI = b;
      for (int j = 0; j < HALF; j++) begin
        smpl_stb = (i == stb_bit) && (j == 0);
        @(negedge clk);
      end
      smpl_stb = 1'b0;
      if (i < 16) r = {r[14:0], MISO};
      SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    SS_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic xfer(input logic [15:0] w, input int nbits, input int stb_bit,
                      output logic [15:0] r);
    spi_frame(w, nbits, stb_bit, r);
    model_frame(w, nbits, (stb_bit >= 0) && (stb_bit < nbits));
  endtask

  task automatic idle_strobe(input logic [15:0] p, input logic [15:0] r, input logic [15:0] y);
    @(negedge clk);
    ptch_rt = p; roll_rt = r; yaw_rt = y;
    smpl_stb = 1'b1;
    @(negedge clk);
    smpl_stb = 1'b0;
    model_capture(p, r, y, m_regs[7'h0D][1]);
  endtask

  task automatic test_reset();
    rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0; smpl_stb = 1'b0;
    ptch_rt = 16'h0; roll_rt = 16'h0; yaw_rt = 16'h0;
    model_reset();
    repeat (3) @(negedge clk);
    total++; if (MISO !== 1'b0) $display("FAIL reset_miso: got %b want 0", MISO); else passed++;
    total++; if (INT !== 1'b0) $display("FAIL reset_int: got %b want 0", INT); else passed++;
    total++; if (int_en !== 1'b0) $display("FAIL reset_int_en: got %b want 0", int_en); else passed++;
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_whoami();
    logic [15:0] r;
    xfer(16'h8F00, 16, -1, r);
    total++; if (r !== 16'h006A) $display("FAIL whoami: got %h want 006a", r); else passed++;
    total++; if (INT !== 1'b0) $display("FAIL whoami_int: got %b want 0", INT); else passed++;
    total++; if (MISO !== 1'b0) $display("FAIL miso_idle: got %b want 0", MISO); else passed++;
  endtask

  task automatic test_int_flow();
    logic [15:0] r;
    xfer(16'h0D02, 16, -1, r);
    total++; if (int_en !== 1'b1) $display("FAIL int_en_set: got %b want 1", int_en); else passed++;
    idle_strobe(16'h1234, 16'hA5A5, 16'h5577);
    if (INT !== 1'b1) @(negedge clk);
    total++; if (INT !== 1'b1) $display("FAIL int_on_capture: got %b want 1", INT); else passed++;
    xfer(16'hA200, 16, -1, r);
    total++; if (r !== 16'h0034) $display("FAIL ptch_l: got %h want 0034", r); else passed++;
    xfer(16'hA300, 16, -1, r);
    total++; if (r !== 16'h0012) $display("FAIL ptch_h: got %h want 0012", r); else passed++;
  endtask

  task automatic test_int_clear();
    logic [15:0] r;
    xfer(16'hA600, 16, -1, r);
    total++; if (r !== 16'h0077) $display("FAIL yaw_l_read: got %h want 0077", r); else passed++;
    total++; if (INT !== 1'b1) $display("FAIL int_kept_a6: got %b want 1", INT); else passed++;
    xfer(16'hA700, 16, -1, r);
    total++; if (r !== 16'h0055) $display("FAIL yaw_h_read: got %h want 0055", r); else passed++;
    total++; if (INT !== 1'b0) $display("FAIL int_clr_a7: got %b want 0", INT); else passed++;
  endtask

  task automatic test_abort();
    logic [15:0] r;
    xfer(16'h1160, 10, -1, r);
    xfer(16'h9100, 16, -1, r);
    total++; if (r !== 16'h0000) $display("FAIL abort_no_write: got %h want 0000", r); else passed++;
    xfer(16'h8F00, 16, -1, r);
    total++; if (r !== 16'h006A) $display("FAIL after_abort: got %h want 006a", r); else passed++;
    xfer(16'h1160, 16, -1, r);
    xfer(16'h9100, 16, -1, r);
    total++; if (r !== 16'h0060) $display("FAIL full_write: got %h want 0060", r); else passed++;
  endtask

  task automatic test_hold_ignore();
    logic [15:0] r;
    xfer(16'h105A, 21, -1, r);
    xfer(16'h9000, 16, -1, r);
    total++; if (r !== 16'h005A) $display("FAIL hold_ignore: got %h want 005a", r); else passed++;
  endtask

  task automatic test_pending();
    logic [15:0] r;
    ptch_rt = 16'($urandom); roll_rt = 16'($urandom); yaw_rt = 16'hBEEF;
    xfer(16'hA600, 16, 3, r);
    total++; if (r !== 16'h0077) $display("FAIL pend_old: got %h want 0077", r); else passed++;
    total++; if (INT !== 1'b1) $display("FAIL pend_int: got %b want 1", INT); else passed++;
    xfer(16'hA600, 16, -1, r);
    total++; if (r !== 16'h00EF) $display("FAIL pend_yaw_l: got %h want 00ef", r); else passed++;
    xfer(16'hA700, 16, -1, r);
    total++; if (r !== 16'h00BE) $display("FAIL pend_yaw_h: got %h want 00be", r); else passed++;
  endtask

  task automatic test_random();
    logic [15:0] r, exp;
    logic [6:0]  a;
    logic [7:0]  d;
    for (int n = 0; n < 30; n++) begin
      d = 8'($urandom);
      case ($urandom_range(0, 3))
        0: begin
          case ($urandom_range(0, 2))
            0: a = 7'h0D;
            1: a = 7'h10;
            default: a = 7'h11;
          endcase
          xfer({1'b0, a, d}, 16, -1, r);
          total++;
          if (int_en !== m_regs[7'h0D][1] || INT !== m_int)
            $display("FAIL rnd_wr a=%h: int_en/INT %b%b want %b%b", a, int_en, INT, m_regs[7'h0D][1], m_int);
          else passed++;
        end
        1: begin
          a = 7'($urandom_range(0, 127));
          if (is_rw(a)) a = 7'h0F;
          xfer({1'b0, a, d}, 16, -1, r);
          xfer({1'b1, a, 8'h00}, 16, -1, r);
          exp = {8'h00, m_regs[a]};
          total++;
          if (r !== exp) $display("FAIL rnd_ro a=%h: got %h want %h", a, r, exp); else passed++;
        end
        2: begin
          a = ($urandom_range(0, 1) != 0) ? 7'(7'h20 + $urandom_range(0, 7))
                                          : 7'($urandom_range(0, 127));
          exp = {8'h00, m_regs[a]};
          xfer({1'b1, a, d}, 16, -1, r);
          total++;
          if (r !== exp || INT !== m_int)
            $display("FAIL rnd_rd a=%h: got %h/%b want %h/%b", a, r, INT, exp, m_int);
          else passed++;
        end
        default: begin
          idle_strobe(16'($urandom), 16'($urandom), 16'($urandom));
          repeat (2) @(negedge clk);
          total++;
          if (INT !== m_int) $display("FAIL rnd_stb: INT %b want %b", INT, m_int); else passed++;
        end
      endcase
    end
  endtask

  task automatic test_rst_mid();
    logic [15:0] r, w;
    xfer(16'h0D02, 16, -1, r);
    idle_strobe(16'h1111, 16'h2222, 16'h3333);
    @(negedge clk);
    total++; if (INT !== 1'b1) $display("FAIL pre_rst_int: got %b want 1", INT); else passed++;
    w = 16'h0D02;
    SS_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      SCLK = 1'b0; MOSI = w[15 - i];
      repeat (HALF) @(negedge clk);
      SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    rst = 1'b1;
    #1;
    total++; if (int_en !== 1'b0) $display("FAIL rst_int_en: got %b want 0", int_en); else passed++;
    total++; if (INT !== 1'b0) $display("FAIL rst_int: got %b want 0", INT); else passed++;
    total++; if (MISO !== 1'b0) $display("FAIL rst_miso: got %b want 0", MISO); else passed++;
    @(negedge clk);
    SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    xfer(16'h8F00, 16, -1, r);
    total++; if (r !== 16'h006A) $display("FAIL rst_whoami: got %h want 006a", r); else passed++;
    xfer(16'h8D00, 16, -1, r);
    total++; if (r !== 16'h0000) $display("FAIL rst_int1_ctrl: got %h want 0000", r); else passed++;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_whoami();
    test_int_flow();
    test_int_clear();
    test_abort();
    test_hold_ignore();
    test_pending();
    test_random();
    test_rst_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
